// File: rtl/pulse_sync_src.sv
// rtl/pulse_sync_src.sv - source half of a toggle-based pulse synchronizer
// Optional feature macro: PULSE_QUEUE_EN (adds pending-pulse counter and pend port)
// Ports:
//   clk_src  source clock, the only clock used here
//   rst_n    reset, asynchronous assert, active-low
//   d_in     single-cycle pulse request, clk_src domain
//   ack      destination's synchronized copy of tq (asynchronous level)
//   tq       registered toggle sent to the destination synchronizer
//   busy     registered, high while a toggle is in flight
//   drop     registered, one-cycle flag that a d_in pulse was lost
//   pend     queued pulse count, CNT_W bits (PULSE_QUEUE_EN only)
module pulse_sync_src #(
  parameter int CNT_W = 4
) (
  input  logic             clk_src,
  input  logic             rst_n,
  input  logic             d_in,
  input  logic             ack,
  output logic             tq,
  output logic             busy,
  output logic             drop
`ifdef PULSE_QUEUE_EN
  ,
  output logic [CNT_W-1:0] pend
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("pulse_sync_src: CNT_W must be at least 1");
  end

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nx;
  logic   r_ack_s1;
  logic   r_ack_s2;
  logic   r_tq;
  logic   r_busy;
  logic   r_drop;
  logic   w_tq_nx;
  logic   w_busy_nx;
  logic   w_drop_nx;
  logic   w_pend_nz;

`ifdef PULSE_QUEUE_EN
  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_pend;
  logic [CNT_W-1:0] w_pend_nx;

  assign w_pend_nz = (r_pend != '0);
`else
  assign w_pend_nz = 1'b0;
`endif

  // ack comes from another clock domain: two flops before anything looks at it
  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_s1 <= 1'b0;
      r_ack_s2 <= 1'b0;
    end else begin
      r_ack_s1 <= ack;
      r_ack_s2 <= r_ack_s1;
    end
  end

  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tq    <= 1'b0;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_tq    <= w_tq_nx;
      r_busy  <= w_busy_nx;
      r_drop  <= w_drop_nx;
    end
  end

`ifdef PULSE_QUEUE_EN
  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nx;
    end
  end
`endif

  always_comb begin
    w_state_nx = r_state;
    w_tq_nx    = r_tq;
    w_drop_nx  = 1'b0;
`ifdef PULSE_QUEUE_EN
    w_pend_nx  = r_pend;
`endif
    case (r_state)
      IDLE: begin
        // ack moving while idle is ignored: only a launch changes tq/state
        if (d_in || w_pend_nz) begin
          w_tq_nx    = ~r_tq;
          w_state_nx = WAIT_ACK;
`ifdef PULSE_QUEUE_EN
          // with d_in also high, one queued pulse goes out and d_in takes its slot
          if (!d_in) begin
            w_pend_nx = r_pend - PEND_ONE;
          end
`endif
        end
      end
      WAIT_ACK: begin
        if (r_ack_s2 == r_tq) begin
          w_state_nx = IDLE;
        end
        // a pulse arriving on the returning cycle is still treated as in-flight
        if (d_in) begin
`ifdef PULSE_QUEUE_EN
          if (r_pend != PEND_MAX) begin
            w_pend_nx = r_pend + PEND_ONE;
          end else begin
            w_drop_nx = 1'b1;
          end
`else
          w_drop_nx = 1'b1;
`endif
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
    w_busy_nx = (w_state_nx == WAIT_ACK);
  end

  assign tq   = r_tq;
  assign busy = r_busy;
  assign drop = r_drop;
`ifdef PULSE_QUEUE_EN
  assign pend = r_pend;
`endif

endmodule

// File: tb/tb_pulse_sync_src.sv
// tb/tb_pulse_sync_src.sv - self-checking bench for pulse_sync_src with looped-back destination
`timescale 1ns/1ps
module tb_pulse_sync_src;

  localparam int CNT_W = 4;
  localparam int PMAX  = (1 << CNT_W) - 1;
`ifdef PULSE_QUEUE_EN
  localparam bit QMODE = 1'b1;
`else
  localparam bit QMODE = 1'b0;
`endif

  logic clk_src = 1'b0;
  logic clk_a = 1'b0;
  logic rst_n = 1'b0;
  logic d_in = 1'b0;
  logic dst_async = 1'b0;
  logic dst_hold = 1'b0;
  logic clk_dst;
  logic ack;
  logic tq;
  logic busy;
  logic drop;
  logic dst_s1;
  logic dst_s2;
  logic dst_s3;
  int   dst_pulses = 0;
`ifdef PULSE_QUEUE_EN
  logic [CNT_W-1:0] pend;
`endif

  always #5 clk_src = ~clk_src;

  // ~1.7x clk_src; edges land on odd picoseconds so they never coincide with clk_src edges
  initial begin
    #0.001;
    forever #2.942 clk_a = ~clk_a;
  end

  assign clk_dst = dst_async ? clk_a : ~clk_src;
  assign ack     = dst_s2;

  pulse_sync_src #(.CNT_W(CNT_W)) dut (
    .clk_src (clk_src),
    .rst_n   (rst_n),
    .d_in    (d_in),
    .ack     (ack),
    .tq      (tq),
    .busy    (busy),
    .drop    (drop)
`ifdef PULSE_QUEUE_EN
    ,
    .pend    (pend)
`endif
  );

  // destination: 2-flop synchronizer of tq, ack taken from the second flop, edge detect counts pulses
  always @(posedge clk_dst or negedge rst_n) begin
    if (!rst_n) begin
      dst_s1 <= 1'b0;
      dst_s2 <= 1'b0;
      dst_s3 <= 1'b0;
    end else if (!dst_hold) begin
      dst_s1 <= tq;
      dst_s2 <= dst_s1;
      dst_s3 <= dst_s2;
      if (dst_s2 != dst_s3) dst_pulses <= dst_pulses + 1;
    end
  end

  // reference model: counts launches (tq is their parity), tracks in-flight, queue depth, drops
  logic m_busy, m_drop, m_h0, m_h1;
  int   m_launch, m_pend;
  logic nx_busy, nx_drop;
  int   nx_launch, nx_pend;

  always @* begin
    nx_busy   = m_busy;
    nx_drop   = 1'b0;
    nx_launch = m_launch;
    nx_pend   = m_pend;
    if (!m_busy) begin
      if (d_in || m_pend != 0) begin
        nx_launch = m_launch + 1;
        nx_busy   = 1'b1;
        if (!d_in) nx_pend = m_pend - 1;
      end
    end else begin
      // m_h1 is the ack level seen two source edges ago
      if (m_h1 == m_launch[0]) nx_busy = 1'b0;
      if (d_in) begin
        if (QMODE && m_pend < PMAX) nx_pend = m_pend + 1;
        else nx_drop = 1'b1;
      end
    end
  end

  always @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   <= 1'b0;
      m_drop   <= 1'b0;
      m_h0     <= 1'b0;
      m_h1     <= 1'b0;
      m_launch <= 0;
      m_pend   <= 0;
    end else begin
      m_busy   <= nx_busy;
      m_drop   <= nx_drop;
      m_launch <= nx_launch;
      m_pend   <= nx_pend;
      m_h0     <= ack;
      m_h1     <= m_h0;
    end
  end

  int   n_chk = 0;
  int   n_pass = 0;
  int   tog_cnt = 0;
  int   drop_cnt = 0;
  int   busy_cnt = 0;
  int   pend_peak = 0;
  logic last_tq = 1'b0;
  logic last_busy = 1'b0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cmp_cycle();
    chk(tq == m_launch[0], "tq_vs_model", int'(tq), int'(m_launch[0]));
    chk(busy == m_busy, "busy_vs_model", int'(busy), int'(m_busy));
    chk(drop == m_drop, "drop_vs_model", int'(drop), int'(m_drop));
`ifdef PULSE_QUEUE_EN
    chk(int'(pend) == m_pend, "pend_vs_model", int'(pend), m_pend);
    if (int'(pend) > pend_peak) pend_peak = int'(pend);
`endif
    chk(!(tq != last_tq && last_busy), "toggle_while_busy", int'(tq), int'(last_tq));
    if (tq != last_tq) tog_cnt++;
    if (busy) busy_cnt++;
    if (drop) drop_cnt++;
    last_tq   = tq;
    last_busy = busy;
  endtask

  // drive d_in for the coming edge, compare on the falling edge, return just after the next rising edge
  task automatic step(input logic din);
    d_in = din;
    @(negedge clk_src);
    cmp_cycle();
    @(posedge clk_src);
    #1;
  endtask

  int t0, d0, b0, l0, p0, npulse;
  logic din_r;

  initial begin
    @(posedge clk_src);
    #1;
    repeat (3) step(1'b0);
    chk(tq == 1'b0, "reset_tq", int'(tq), 0);
    chk(busy == 1'b0, "reset_busy", int'(busy), 0);
    chk(drop == 1'b0, "reset_drop", int'(drop), 0);
`ifdef PULSE_QUEUE_EN
    chk(int'(pend) == 0, "reset_pend", int'(pend), 0);
`endif

    // single pulse on the first edge after reset release
    rst_n = 1'b1;
    t0 = tog_cnt; d0 = drop_cnt; b0 = busy_cnt;
    step(1'b1);
    repeat (10) step(1'b0);
    chk(busy_cnt - b0 == 4, "single_busy_cycles", busy_cnt - b0, 4);
    chk(tog_cnt - t0 == 1, "single_toggles", tog_cnt - t0, 1);
    chk(drop_cnt - d0 == 0, "single_drops", drop_cnt - d0, 0);
    chk(tq == 1'b1, "single_tq", int'(tq), 1);
    chk(m_launch == 1, "model_single_launch", m_launch, 1);

    // three pulses one idle cycle apart
    t0 = tog_cnt; d0 = drop_cnt; pend_peak = 0;
    step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b1);
    repeat (20) step(1'b0);
    chk(tog_cnt - t0 == (QMODE ? 3 : 1), "three_toggles", tog_cnt - t0, QMODE ? 3 : 1);
    chk(drop_cnt - d0 == (QMODE ? 0 : 2), "three_drops", drop_cnt - d0, QMODE ? 0 : 2);
`ifdef PULSE_QUEUE_EN
    chk(pend_peak == 2, "three_pend_peak", pend_peak, 2);
    chk(int'(pend) == 0, "three_pend_end", int'(pend), 0);

    // destination stalled: 20 pulses while busy saturate the queue
    t0 = tog_cnt; d0 = drop_cnt; pend_peak = 0;
    dst_hold = 1'b1;
    step(1'b1);
    repeat (20) step(1'b1);
    dst_hold = 1'b0;
    repeat (120) step(1'b0);
    chk(pend_peak == 15, "sat_pend_peak", pend_peak, 15);
    chk(drop_cnt - d0 == 5, "sat_drops", drop_cnt - d0, 5);
    chk(tog_cnt - t0 == 16, "sat_toggles", tog_cnt - t0, 16);
    chk(int'(pend) == 0, "sat_pend_end", int'(pend), 0);
`endif

    // reset in the middle of a transfer
    step(1'b1);
    step(1'b0);
    step(1'b0);
    chk(tq == 1'b1 && busy == 1'b1, "pre_reset_inflight", int'({tq, busy}), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk(tq == 1'b0, "midreset_tq", int'(tq), 0);
    chk(busy == 1'b0, "midreset_busy", int'(busy), 0);
    chk(drop == 1'b0, "midreset_drop", int'(drop), 0);
`ifdef PULSE_QUEUE_EN
    chk(int'(pend) == 0, "midreset_pend", int'(pend), 0);
`endif
    last_tq   = tq;
    last_busy = busy;
    @(posedge clk_src);
    #1;
    repeat (2) step(1'b0);
    rst_n = 1'b1;
    t0 = tog_cnt; d0 = drop_cnt; b0 = busy_cnt;
    step(1'b1);
    repeat (10) step(1'b0);
    chk(tog_cnt - t0 == 1, "post_reset_toggles", tog_cnt - t0, 1);
    chk(busy_cnt - b0 == 4, "post_reset_busy_cycles", busy_cnt - b0, 4);
    chk(drop_cnt - d0 == 0, "post_reset_drops", drop_cnt - d0, 0);

    // asynchronous destination clock, random pulses
    dst_async = 1'b1;
    repeat (5) step(1'b0);
    t0 = tog_cnt; d0 = drop_cnt; l0 = m_launch; p0 = dst_pulses;
    npulse = 0;
    while (npulse < 1000) begin
      din_r = ($urandom_range(0, 2) == 0);
      if (din_r) npulse++;
      step(din_r);
    end
    repeat (200) step(1'b0);
    chk(dst_pulses - p0 == tog_cnt - t0, "async_dst_pulses", dst_pulses - p0, tog_cnt - t0);
    chk(m_launch - l0 == tog_cnt - t0, "async_model_launches", tog_cnt - t0, m_launch - l0);
    chk((tog_cnt - t0) + (drop_cnt - d0) == 1000, "async_launched_plus_dropped",
        (tog_cnt - t0) + (drop_cnt - d0), 1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
